// File: rtl/blokus_uart_pkg.sv
// Shared definitions for the Blokus UART front end.
//
// Contents:
//   rx_state_e       receiver FSM state encoding
//   DEF_*            default timing/format constants (50 MHz clock, 115200 baud, 8N1)
//   cnt_width()      counter width helper, usable when declaring localparams
package blokus_uart_pkg;

    // Receiver FSM states. BREAK absorbs a line held low after a framing error.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int DEF_CLKS_PER_TICK = 27;
    localparam int DEF_OVERSAMPLE    = 16;
    localparam int DEF_DATA_BITS     = 8;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blokus_baud_tick.sv
// Oversample tick generator.
//
// Counts clk cycles 0..CLKS_PER_TICK-1 and raises tick for one cycle on the
// last count. clear restarts the count so the tick phase can be re-aligned to
// an external event, such as a detected start edge.
//
// Ports:
//   clk    input   system clock, rising edge
//   reset  input   asynchronous reset, active low
//   clear  input   restart the count at 0 (suppresses tick in that cycle)
//   tick   output  one-cycle pulse every CLKS_PER_TICK cycles
module blokus_baud_tick
    import blokus_uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_TICK);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST) && !clear;

endmodule

// File: rtl/blokus_uart_rx.sv
// UART receiver (8N1, LSB first) feeding the Blokus stream wrapper.
//
// rx is synchronised through two flops, then sampled at mid-bit using a
// 16x-style oversample tick whose phase is re-aligned on each start edge.
// Only frames with a high stop bit produce a wr pulse; a low stop bit raises
// frame_err, bumps a saturating error counter, and parks the FSM in BREAK
// until the line returns high.
//
// Ports:
//   clk        input   system clock, rising edge
//   reset      input   asynchronous reset, active low
//   rx         input   asynchronous serial line, idle high
//   wr         output  one-cycle pulse, data_out holds a new byte
//   data_out   output  last good byte, held until the next wr
//   frame_err  output  one-cycle pulse, stop bit sampled low
//   busy       output  high while a frame is being received
//   err_count  output  saturating framing-error count
module blokus_uart_rx
    import blokus_uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
    parameter int OVERSAMPLE    = DEF_OVERSAMPLE,
    parameter int DATA_BITS     = DEF_DATA_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       wr,
    output logic [7:0] data_out,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int SW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS);

    // Start bit is checked half a bit in; every later sample is a full bit apart.
    localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_e       state_q, state_d;
    logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            wr_q, wr_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            tick;
    logic            tick_clear;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    blokus_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    // Frame FSM. Counters only move on tick, except for the clear on start detect.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        wr_d         = 1'b0;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
        tick_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d      = ST_START;
                    tick_clear   = 1'b1;
                    sample_cnt_d = '0;
                    bit_idx_d    = '0;
                    shift_d      = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (sample_cnt_q == SAMPLE_MID) begin
                        sample_cnt_d = '0;
                        // A line already back high mid start bit was only a glitch.
                        state_d      = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        sample_cnt_d       = '0;
                        shift_d[bit_idx_q] = rx_s_q;
                        bit_idx_d          = bit_idx_q + BW'(1);
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        sample_cnt_d = '0;
                        if (rx_s_q) begin
                            data_out_d = shift_q;
                            wr_d       = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
                            state_d = ST_BREAK;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end
            end

            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            wr_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            wr_q         <= wr_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign wr        = wr_q;
    assign data_out  = data_out_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_blokus_uart_rx.sv
// Directed testbench for blokus_uart_rx.
//
// The main instance runs at 4 clk per tick, 16 ticks per bit (64 clk per bit).
// A second, faster instance (2 clk per tick, 4 ticks per bit) is used only for
// the error-counter saturation run so hundreds of frames stay cheap.
module tb_blokus_uart_rx;

    localparam int BIT_CLKS  = 64;
    localparam int BIT2_CLKS = 8;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       wr;
    logic [7:0] data_out;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    logic       rx2;
    logic       wr2;
    logic [7:0] data_out2;
    logic       frame_err2;
    logic       busy2;
    logic [7:0] err_count2;

    int checks;
    int errors;

    int cycle;
    int wrCount;
    int ferrCount;
    int widthErr;
    int overlapErr;
    int lastWrCycle;
    int prevWrCycle;
    logic [7:0] lastWrData;
    logic [7:0] prevWrData;
    logic prevWr;

    int wr2Count;
    int ferr2Count;
    int overlap2Err;

    int wrBase;
    int ferrBase;

    blokus_uart_rx #(
        .CLKS_PER_TICK(4),
        .OVERSAMPLE   (16),
        .DATA_BITS    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .wr       (wr),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy),
        .err_count(err_count)
    );

    blokus_uart_rx #(
        .CLKS_PER_TICK(2),
        .OVERSAMPLE   (4),
        .DATA_BITS    (8)
    ) dutFast (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx2),
        .wr       (wr2),
        .data_out (data_out2),
        .frame_err(frame_err2),
        .busy     (busy2),
        .err_count(err_count2)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor for the main instance, sampled away from the active edge.
    initial begin
        cycle       = 0;
        wrCount     = 0;
        ferrCount   = 0;
        widthErr    = 0;
        overlapErr  = 0;
        lastWrCycle = 0;
        prevWrCycle = 0;
        lastWrData  = 8'h00;
        prevWrData  = 8'h00;
        prevWr      = 1'b0;
        forever begin
            @(negedge clk);
            cycle = cycle + 1;
            if (wr === 1'b1) begin
                wrCount     = wrCount + 1;
                prevWrCycle = lastWrCycle;
                prevWrData  = lastWrData;
                lastWrCycle = cycle;
                lastWrData  = data_out;
                if (prevWr) widthErr = widthErr + 1;
            end
            if (wr === 1'b1 && frame_err === 1'b1) overlapErr = overlapErr + 1;
            if (frame_err === 1'b1) ferrCount = ferrCount + 1;
            prevWr = (wr === 1'b1);
        end
    end

    // Pulse monitor for the fast instance.
    initial begin
        wr2Count    = 0;
        ferr2Count  = 0;
        overlap2Err = 0;
        forever begin
            @(negedge clk);
            if (wr2 === 1'b1) wr2Count = wr2Count + 1;
            if (frame_err2 === 1'b1) ferr2Count = ferr2Count + 1;
            if (wr2 === 1'b1 && frame_err2 === 1'b1) overlap2Err = overlap2Err + 1;
        end
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic value);
        rx = value;
        idleClocks(BIT_CLKS);
    endtask

    // One 8N1 frame on the main line, LSB first, with a chosen stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stopBit);
    endtask

    // All-low frame on the fast line, then a short high gap to leave BREAK.
    task automatic applyErrorFrameFast();
        rx2 = 1'b0;
        idleClocks(10 * BIT2_CLKS);
        rx2 = 1'b1;
        idleClocks(BIT2_CLKS);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        rx     = 1'b1;
        rx2    = 1'b1;

        // Reset values.
        idleClocks(5);
        checkOutput("reset_wr", {31'd0, wr}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_data_out", {24'd0, data_out}, 32'h00);
        checkOutput("reset_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b1;
        idleClocks(10);

        // Clean byte.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        applyStimulus(8'hA5, 1'b1);
        idleClocks(10);
        checkOutput("a5_wr_pulses", wrCount - wrBase, 32'd1);
        checkOutput("a5_wr_data", {24'd0, lastWrData}, 32'hA5);
        checkOutput("a5_data_out_held", {24'd0, data_out}, 32'hA5);
        checkOutput("a5_no_frame_err", ferrCount - ferrBase, 32'd0);
        checkOutput("a5_busy_low", {31'd0, busy}, 32'd0);

        // Short low glitch is a false start.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        rx = 1'b0;
        idleClocks(20);
        rx = 1'b1;
        idleClocks(100);
        checkOutput("glitch_no_wr", wrCount - wrBase, 32'd0);
        checkOutput("glitch_no_frame_err", ferrCount - ferrBase, 32'd0);
        checkOutput("glitch_err_count", {24'd0, err_count}, 32'd0);
        checkOutput("glitch_idle", {31'd0, busy}, 32'd0);

        // Low stop bit followed by a held-low line: exactly one error.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        applyStimulus(8'h3C, 1'b0);
        rx = 1'b0;
        idleClocks(200);
        checkOutput("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        idleClocks(BIT_CLKS);
        checkOutput("ferr_pulses", ferrCount - ferrBase, 32'd1);
        checkOutput("ferr_no_wr", wrCount - wrBase, 32'd0);
        checkOutput("ferr_err_count", {24'd0, err_count}, 32'd1);
        checkOutput("ferr_data_out_kept", {24'd0, data_out}, 32'hA5);
        checkOutput("ferr_back_idle", {31'd0, busy}, 32'd0);
        wrBase = wrCount;
        applyStimulus(8'h5A, 1'b1);
        idleClocks(10);
        checkOutput("after_break_wr", wrCount - wrBase, 32'd1);
        checkOutput("after_break_data", {24'd0, data_out}, 32'h5A);

        // Back-to-back frames with a single stop bit.
        wrBase = wrCount;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        idleClocks(10);
        checkOutput("b2b_wr_pulses", wrCount - wrBase, 32'd2);
        checkOutput("b2b_first_data", {24'd0, prevWrData}, 32'h00);
        checkOutput("b2b_second_data", {24'd0, lastWrData}, 32'hFF);
        checkOutput("b2b_spacing", lastWrCycle - prevWrCycle, 32'd640);

        // Reset in the middle of bit 4 of 8'h81.
        wrBase = wrCount;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b0);
        rx = 1'b0;
        idleClocks(BIT_CLKS / 2);
        reset = 1'b0;
        #1;
        checkOutput("midreset_wr", {31'd0, wr}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midreset_data_out", {24'd0, data_out}, 32'h00);
        checkOutput("midreset_err_count", {24'd0, err_count}, 32'd0);
        rx = 1'b1;
        idleClocks(10);
        reset = 1'b1;
        idleClocks(BIT_CLKS * 4);
        checkOutput("midreset_no_wr", wrCount - wrBase, 32'd0);
        applyStimulus(8'h81, 1'b1);
        idleClocks(10);
        checkOutput("post_reset_wr", wrCount - wrBase, 32'd1);
        checkOutput("post_reset_data", {24'd0, data_out}, 32'h81);

        // Pulse shape over the whole main-instance run.
        checkOutput("wr_width_one", widthErr, 32'd0);
        checkOutput("wr_ferr_exclusive", overlapErr, 32'd0);

        // Saturation of the error counter on the fast instance.
        for (int i = 0; i < 254; i++) applyErrorFrameFast();
        checkOutput("sat_count_254", {24'd0, err_count2}, 32'd254);
        applyErrorFrameFast();
        checkOutput("sat_count_255", {24'd0, err_count2}, 32'd255);
        for (int i = 0; i < 5; i++) applyErrorFrameFast();
        checkOutput("sat_count_260", {24'd0, err_count2}, 32'd255);
        checkOutput("sat_ferr_pulses", ferr2Count, 32'd260);
        checkOutput("sat_no_wr", wr2Count, 32'd0);
        checkOutput("sat_exclusive", overlap2Err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blokus_uart_rx.md
Name: blokus_uart_rx

Overview:
- Serial-to-byte front end that sits directly upstream of the Blokus stream wrapper.
- Drives the wrapper's byte-write interface (wr, data_in) into the producer FIFO from a host UART line (8N1, LSB first).
- Uses 16x oversampling with mid-bit sampling.
- Rejects false starts and framing errors, so only well-formed bytes ever reach the producer FIFO.

Parameters:
- CLKS_PER_TICK, 27: clk cycles per oversample tick (50 MHz / (115200*16) rounded). Must be >= 2.
- OVERSAMPLE, 16: ticks per bit. Must be even and >= 4.
- DATA_BITS, 8: data bits per frame. data_out width is fixed at 8; valid values 5..8, received into data_out[DATA_BITS-1:0], upper bits zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  asynchronous serial line, idle high.
- wr  output  1  one-cycle pulse: data_out holds a valid byte (connects to wrapper wr).
- data_out  output  8  received byte, held stable until the next wr (connects to wrapper data_in).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high from accepted start edge until return to IDLE.
- err_count  output  8  saturating count of framing errors.

Behaviour:
- Reset (reset low, async):
  - wr=0, frame_err=0, busy=0, data_out=8'h00, err_count=0.
  - Synchroniser flops = 1; FSM = IDLE; tick and bit counters = 0.
  - Reset mid-frame abandons the partial byte with no wr pulse.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s; nothing reads raw rx.
- Tick generator: counter 0..CLKS_PER_TICK-1, emits a one-cycle tick on wrap.
  - Forced to 0 on IDLE->START so bit phase aligns to the detected edge.
- Sample counter (0..OVERSAMPLE-1) advances on tick only.
- IDLE:
  - busy=0.
  - rx_s==0 -> START, clear counters, busy=1.
- START:
  - After OVERSAMPLE/2 ticks, sample rx_s.
  - 0 -> DATA, bit index=0, sample counter=0.
  - 1 -> false start: IDLE, no output pulses.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into shift register (LSB first), bit index++.
  - After DATA_BITS samples -> STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - 1: data_out <= shift register and wr=1 for exactly one clk (registered, the cycle after the sampling tick) -> IDLE.
  - 0: frame_err=1 for one clk, err_count += 1 (saturates at 255, no wrap), data_out unchanged, no wr -> BREAK.
- BREAK:
  - Waits until rx_s==1, then -> IDLE.
  - Prevents a held-low line (break) from generating repeated errors.
- Pulse exclusivity: wr and frame_err are never high in the same cycle.
- Back-to-back frames:
  - A start edge may be detected in the first IDLE cycle after STOP, so minimum frame spacing is 1 stop bit.
  - Never drops consecutive bytes.
- No backpressure: the producer FIFO must have capacity. wr is emitted regardless (FIFO full is the integrator's responsibility).
- Latency: wr rises (DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2 ticks, + 3..4 clk, after rx falls.

Decomposition:
- Package blokus_uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - default constants for CLKS_PER_TICK, OVERSAMPLE and DATA_BITS;
  - a localparam function for counter widths ($clog2).
- Sub-module blokus_baud_tick (parameter CLKS_PER_TICK; ports clk, reset, clear, tick). Reusable by a future blokus_uart_tx downstream of the consumer FIFO.
- The synchroniser stays inline.

Test Plan:
All scenarios use CLKS_PER_TICK=4, OVERSAMPLE=16 (1 bit = 64 clk).
- Send 8'hA5 (8N1) -> exactly one wr pulse, 1 clk wide; data_out=8'hA5; frame_err never high; busy low afterwards.
- rx low glitch of 20 clk, then high -> no wr, no frame_err, err_count=0, FSM back in IDLE.
- Send 8'h3C with stop bit low, then hold rx low 200 clk, then high -> one frame_err pulse, no wr, err_count=1, data_out unchanged; then send 8'h5A -> wr with data_out=8'h5A.
- Send 8'h00 then 8'hFF back-to-back (one stop bit each) -> two wr pulses 640 clk apart with data 8'h00, 8'hFF.
- Assert reset (low) during bit 4 of 8'h81 -> all outputs at reset values immediately, no wr; after release, send 8'h81 -> wr with data_out=8'h81.
- Force 260 framing errors -> err_count stops at 255 and does not wrap.
